button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter: STABLE_CYCLES, default 1000000, number of consecutive synchronized samples required to accept a new button level; legal range >= 2.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: btn_in  input  1  raw mechanical button, asynchronous to clk, may bounce.
REQ-005 Port: btn_level  output  1  debounced button level, registered.
REQ-006 Port: press_pulse  output  1  single-cycle strobe on accepted press (0->1), registered; drives the downstream counter's advance.
REQ-007 Port: release_pulse  output  1  single-cycle strobe on accepted release (1->0), registered.

Function
REQ-008 The block SHALL pass btn_in through a two-flop synchronizer; only the second stage (btn_sync) feeds the rest of the logic.
REQ-009 The block SHALL contain a stability counter of width $clog2(STABLE_CYCLES) and a four-state FSM: IDLE, CHECK_HIGH, HIGH, CHECK_LOW.
REQ-010 In IDLE with btn_sync=1, the FSM SHALL go to CHECK_HIGH and clear the counter to 0; otherwise it stays in IDLE.
REQ-011 In CHECK_HIGH with btn_sync=0, the FSM SHALL return to IDLE and clear the counter; no pulse is produced.
REQ-012 In CHECK_HIGH with btn_sync=1 and counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 In CHECK_HIGH with btn_sync=1 and counter == STABLE_CYCLES-1, the FSM SHALL go to HIGH, clear the counter, and set press_pulse=1 on that same edge.
REQ-014 In HIGH with btn_sync=0, the FSM SHALL go to CHECK_LOW and clear the counter; otherwise it stays in HIGH.
REQ-015 The CHECK_LOW rules SHALL mirror REQ-011 to REQ-013: with btn_sync=1, return to HIGH with no pulse; with btn_sync=0 and counter == STABLE_CYCLES-1, go to IDLE and set release_pulse=1.
REQ-016 btn_level SHALL be registered and equal 1 exactly when the FSM is in HIGH or CHECK_LOW.
REQ-017 press_pulse and release_pulse SHALL each be high for exactly one clock cycle per accepted transition, and never high together.
REQ-018 Latency: if btn_in is first sampled high at edge 0 and stays high, btn_level and press_pulse SHALL rise after edge 2+STABLE_CYCLES (edge 6 for STABLE_CYCLES=4); release latency SHALL be identical.
REQ-019 Any synchronized glitch shorter than STABLE_CYCLES samples SHALL leave btn_level unchanged and generate no pulse.
REQ-020 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 reset SHALL take priority over all other inputs.
REQ-022 When reset is asserted, the synchronizer flops SHALL be set to 0, the counter to 0, and the FSM to IDLE.
REQ-023 While reset is asserted, btn_level, press_pulse and release_pulse SHALL be 0 from the first clock edge at which reset is sampled high.
REQ-024 Reset asserted in CHECK_HIGH or CHECK_LOW SHALL abort qualification; no pulse SHALL be emitted for that transition.
REQ-025 If btn_in is held high through reset deassertion, the block SHALL re-qualify it from IDLE and emit one press_pulse after the REQ-018 latency.

Verification (STABLE_CYCLES=4)
REQ-026 Clean press: btn_in 0->1 sampled at edge 0 and held for 20 cycles -> btn_level=1 and press_pulse=1 after edge 6; press_pulse=0 after edge 7; release_pulse stays 0.
REQ-027 Bounce: btn_in toggles 1,0,1,0 at single-cycle intervals, then holds 1 -> no pulse during the bounce; exactly one press_pulse, 6 edges after the final stable rise.
REQ-028 Release: from HIGH, btn_in 1->0 held for 10 cycles -> btn_level falls and release_pulse is high for exactly 1 cycle after 6 edges.
REQ-029 Short glitch: in HIGH, btn_in low for 3 cycles -> btn_level stays 1; no release_pulse.
REQ-030 Mid-qualification reset: reset asserted 1 cycle in CHECK_HIGH with btn_in held 1 -> all outputs 0 during reset; after deassertion, exactly one press_pulse 6 edges later.
REQ-031 Pulse count: 5 clean press/release cycles -> exactly 5 press_pulse and 5 release_pulse events; a 2-bit downstream counter advanced by press_pulse ends at 1.

Source files
------------

// File: rtl/button_debouncer.sv
// Debounces a raw mechanical button: two-flop synchronizer, then a stability
// FSM that accepts a new level only after STABLE_CYCLES consistent samples.
`timescale 1ns/1ps

// state      | meaning
// IDLE       | accepted level low, waiting for a high sample
// CHECK_HIGH | qualifying a rising level, counting stable high samples
// HIGH       | accepted level high, waiting for a low sample
// CHECK_LOW  | qualifying a falling level, counting stable low samples
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHECK_HIGH = 2'd1,
    HIGH       = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic           btn_meta, btn_sync;
  logic           press_next, release_next, level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta      <= 1'b0;
      btn_sync      <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      btn_meta      <= btn_in;
      btn_sync      <= btn_meta;
      state         <= state_next;
      cnt           <= cnt_next;
      btn_level     <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_next = CHECK_HIGH;
          cnt_next   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!btn_sync) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = HIGH;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!btn_sync) begin
          state_next = CHECK_LOW;
          cnt_next   = '0;
        end
      end
      CHECK_LOW: begin
        if (btn_sync) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Registered level tracks the state being entered, so it lines up with the pulses.
    level_next = (state_next == HIGH) || (state_next == CHECK_LOW);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (STABLE_CYCLES=4): expected pulse
// events are queued at stimulus time and matched against observed pulses.
`timescale 1ns/1ps

module tb_button_debouncer;

  localparam int SC = 4;
  localparam int LAT = SC + 3;  // negedge drive at cycle t -> pulse stamped at edge t+LAT

  typedef struct packed {
    logic        rel;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, press_pulse, release_pulse;

  int  cyc = 0;
  int  n_assert = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  button_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (press_pulse)   obs_q.push_back('{rel: 1'b0, cyc: cyc});
    if (release_pulse) obs_q.push_back('{rel: 1'b1, cyc: cyc});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1);
    n_assert++;
    if (btn_level !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b expected 0", btn_level); end
    n_assert++;
    if (press_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_press: got %b expected 0", press_pulse); end
    n_assert++;
    if (release_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %b expected 0", release_pulse); end
    tick(2);
    reset = 1'b0;
    tick(2);
    obs_q.delete();
  endtask

  task automatic test_clean_press();
    int t;
    ev_t e, o;
    t = cyc;
    btn_in = 1'b1;
    exp_q.push_back('{rel: 1'b0, cyc: t + LAT});
    while (cyc < t + LAT - 1) tick(1);
    n_assert++;
    if (btn_level !== 1'b0) begin n_fail++; $display("FAIL press_level_early: got %b expected 0", btn_level); end
    tick(1);
    n_assert++;
    if (btn_level !== 1'b1) begin n_fail++; $display("FAIL press_level_rise: got %b expected 1", btn_level); end
    n_assert++;
    if (press_pulse !== 1'b1) begin n_fail++; $display("FAIL press_pulse_high: got %b expected 1", press_pulse); end
    tick(1);
    n_assert++;
    if (press_pulse !== 1'b0) begin n_fail++; $display("FAIL press_pulse_low: got %b expected 0", press_pulse); end
    while (cyc < t + 20) tick(1);
    n_assert++;
    if (exp_q.size() != obs_q.size()) begin n_fail++; $display("FAIL clean_press_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL clean_press_event: got rel=%b cyc=%0d expected rel=%b cyc=%0d", o.rel, o.cyc, e.rel, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_release();
    int t;
    ev_t e, o;
    t = cyc;
    btn_in = 1'b0;
    exp_q.push_back('{rel: 1'b1, cyc: t + LAT});
    while (cyc < t + LAT - 1) tick(1);
    n_assert++;
    if (btn_level !== 1'b1) begin n_fail++; $display("FAIL release_level_early: got %b expected 1", btn_level); end
    tick(1);
    n_assert++;
    if (btn_level !== 1'b0) begin n_fail++; $display("FAIL release_level_fall: got %b expected 0", btn_level); end
    n_assert++;
    if (release_pulse !== 1'b1) begin n_fail++; $display("FAIL release_pulse_high: got %b expected 1", release_pulse); end
    tick(1);
    n_assert++;
    if (release_pulse !== 1'b0) begin n_fail++; $display("FAIL release_pulse_low: got %b expected 0", release_pulse); end
    while (cyc < t + 12) tick(1);
    n_assert++;
    if (exp_q.size() != obs_q.size()) begin n_fail++; $display("FAIL release_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL release_event: got rel=%b cyc=%0d expected rel=%b cyc=%0d", o.rel, o.cyc, e.rel, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bounce();
    int t;
    ev_t e, o;
    for (int i = 0; i < 4; i++) begin
      btn_in = (i % 2 == 0);
      tick(1);
    end
    t = cyc;
    btn_in = 1'b1;
    exp_q.push_back('{rel: 1'b0, cyc: t + LAT});
    tick(15);
    t = cyc;
    btn_in = 1'b0;
    exp_q.push_back('{rel: 1'b1, cyc: t + LAT});
    tick(12);
    n_assert++;
    if (exp_q.size() != obs_q.size()) begin n_fail++; $display("FAIL bounce_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL bounce_event: got rel=%b cyc=%0d expected rel=%b cyc=%0d", o.rel, o.cyc, e.rel, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    int t;
    int bad;
    ev_t e, o;
    t = cyc;
    btn_in = 1'b1;
    exp_q.push_back('{rel: 1'b0, cyc: t + LAT});
    tick(12);
    btn_in = 1'b0;
    tick(3);
    btn_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (btn_level !== 1'b1) bad++;
    end
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL glitch_level: got %0d low samples expected 0", bad); end
    t = cyc;
    btn_in = 1'b0;
    exp_q.push_back('{rel: 1'b1, cyc: t + LAT});
    tick(12);
    n_assert++;
    if (exp_q.size() != obs_q.size()) begin n_fail++; $display("FAIL glitch_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL glitch_event: got rel=%b cyc=%0d expected rel=%b cyc=%0d", o.rel, o.cyc, e.rel, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mid_reset();
    int t;
    ev_t e, o;
    t = cyc;
    btn_in = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    n_assert++;
    if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 000", {btn_level, press_pulse, release_pulse});
    end
    reset = 1'b0;
    exp_q.push_back('{rel: 1'b0, cyc: t + 4 + LAT});
    tick(15);
    n_assert++;
    if (btn_level !== 1'b1) begin n_fail++; $display("FAIL midreset_level: got %b expected 1", btn_level); end
    t = cyc;
    btn_in = 1'b0;
    exp_q.push_back('{rel: 1'b1, cyc: t + LAT});
    tick(12);
    n_assert++;
    if (exp_q.size() != obs_q.size()) begin n_fail++; $display("FAIL midreset_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL midreset_event: got rel=%b cyc=%0d expected rel=%b cyc=%0d", o.rel, o.cyc, e.rel, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int t;
    int n_press, n_rel;
    logic [1:0] dcnt;
    ev_t e, o;
    n_press = 0; n_rel = 0; dcnt = 2'd0;
    for (int k = 0; k < 5; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        t = cyc;
        btn_in = (ph == 0);
        exp_q.push_back('{rel: logic'(ph), cyc: t + LAT});
        for (int i = 0; i < 11; i++) begin
          tick(1);
          if (press_pulse === 1'b1) begin n_press++; dcnt = dcnt + 2'd1; end
          if (release_pulse === 1'b1) n_rel++;
        end
      end
    end
    n_assert++;
    if (n_press != 5) begin n_fail++; $display("FAIL count_press: got %0d expected 5", n_press); end
    n_assert++;
    if (n_rel != 5) begin n_fail++; $display("FAIL count_release: got %0d expected 5", n_rel); end
    n_assert++;
    if (dcnt !== 2'd1) begin n_fail++; $display("FAIL count_downstream: got %0d expected 1", dcnt); end
    n_assert++;
    if (exp_q.size() != obs_q.size()) begin n_fail++; $display("FAIL b2b_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_event: got rel=%b cyc=%0d expected rel=%b cyc=%0d", o.rel, o.cyc, e.rel, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
